// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants and types for the SPI write-only register slave.
//   FRAME_W / ADDR_W / DATA_W : 16-bit frame = {rw, 7-bit address, 8-bit data}
//   ADDR_*                    : addresses of the five control registers
//   spi_frame_t               : packed view of a received frame
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_frame_t;

endpackage : spi_pkg

// File: rtl/spi_peripheral_if.sv
// -----------------------------------------------------------------------------
// spi_peripheral_if
// Bundles the SPI pins and the control-register outputs of spi_peripheral.
//   slave  : the peripheral (samples pins, drives registers and wr_strobe)
//   master : the SPI host / downstream observer
// Signals:
//   sclk_in, copi_in, ncs_in : SPI pins (asynchronous to the system clock)
//   en_reg_out_7_0 .. pwm_duty_cycle : control registers at 0x00 .. 0x04
//   wr_strobe                : one-cycle pulse per committed write
// -----------------------------------------------------------------------------
interface spi_peripheral_if;
    import spi_pkg::*;

    logic              sclk_in;
    logic              copi_in;
    logic              ncs_in;
    logic [DATA_W-1:0] en_reg_out_7_0;
    logic [DATA_W-1:0] en_reg_out_15_8;
    logic [DATA_W-1:0] en_reg_pwm_7_0;
    logic [DATA_W-1:0] en_reg_pwm_15_8;
    logic [DATA_W-1:0] pwm_duty_cycle;
    logic              wr_strobe;

    modport slave (
        input  sclk_in, copi_in, ncs_in,
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
               en_reg_pwm_15_8, pwm_duty_cycle, wr_strobe
    );

    modport master (
        output sclk_in, copi_in, ncs_in,
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
               en_reg_pwm_15_8, pwm_duty_cycle, wr_strobe
    );

endinterface : spi_peripheral_if

// File: rtl/spi_peripheral_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// N-flop synchroniser for an asynchronous pin with registered edge pulses.
//   clk, rst : system clock, synchronous active-high reset
//   d_i      : asynchronous input pin
//   q_o      : synchronised level (STAGES cycles behind the pin)
//   rise_o   : one-cycle pulse, STAGES+1 cycles after a pin rise
//   fall_o   : one-cycle pulse, STAGES+1 cycles after a pin fall
// All flops reset to RESET_VAL so no edge is reported coming out of reset.
// -----------------------------------------------------------------------------
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    // Synchroniser chain, one extra flop holding the previous synchronised
    // level, and registered edge pulses comparing the two.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
            prev_q  <= chain_q[STAGES-1];
            rise_q  <= chain_q[STAGES-1] & ~prev_q;
            fall_q  <= ~chain_q[STAGES-1] & prev_q;
        end
    end

    assign q_o    = chain_q[STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule : sync_edge

// File: rtl/spi_peripheral.sv
// -----------------------------------------------------------------------------
// spi_peripheral
// SPI mode-0 write-only register slave with five 8-bit control registers.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : spi_peripheral_if.slave (SPI pins in, registers + wr_strobe out)
// A frame commits only when exactly 16 bits arrived, bit15 = 1 (write) and the
// address is <= MAX_ADDR; anything else is dropped without side effects.
// -----------------------------------------------------------------------------
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = 7'h04
) (
    input  logic             clk,
    input  logic             rst,
    spi_peripheral_if.slave  bus
);

    logic sclkSync, sclkRise, sclkFall;
    logic ncsSync,  ncsRise,  ncsFall;
    logic copiSync, copiRise, copiFall;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncSclk (
        .clk(clk), .rst(rst), .d_i(bus.sclk_in),
        .q_o(sclkSync), .rise_o(sclkRise), .fall_o(sclkFall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uSyncNcs (
        .clk(clk), .rst(rst), .d_i(bus.ncs_in),
        .q_o(ncsSync), .rise_o(ncsRise), .fall_o(ncsFall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSyncCopi (
        .clk(clk), .rst(rst), .d_i(bus.copi_in),
        .q_o(copiSync), .rise_o(copiRise), .fall_o(copiFall)
    );

    // Edge outputs this block has no use for.
    logic unusedSyncOutputs;
    assign unusedSyncOutputs = ^{sclkSync, sclkFall, copiRise, copiFall};

    logic [FRAME_W-1:0] shift_q,  shift_d;
    logic [4:0]         count_q,  count_d;
    logic               active_q, active_d;
    logic               strobe_q, strobe_d;
    logic [DATA_W-1:0]  outLo_q,  outLo_d;
    logic [DATA_W-1:0]  outHi_q,  outHi_d;
    logic [DATA_W-1:0]  pwmLo_q,  pwmLo_d;
    logic [DATA_W-1:0]  pwmHi_q,  pwmHi_d;
    logic [DATA_W-1:0]  duty_q,   duty_d;
    spi_frame_t         frame;

    assign frame = shift_q;

    // Frame tracking and register commit. The ncs rising edge takes priority
    // over a coincident sclk edge, so that last bit is never shifted and the
    // commit decision uses the counter as it stood before that cycle.
    always_comb begin
        shift_d  = shift_q;
        count_d  = count_q;
        active_d = active_q;
        strobe_d = 1'b0;
        outLo_d  = outLo_q;
        outHi_d  = outHi_q;
        pwmLo_d  = pwmLo_q;
        pwmHi_d  = pwmHi_q;
        duty_d   = duty_q;

        if (ncsFall) begin
            shift_d  = '0;
            count_d  = '0;
            active_d = 1'b1;
        end else if (ncsRise && active_q) begin
            active_d = 1'b0;
            if (count_q == 5'd16 && frame.rw && frame.addr <= MAX_ADDR) begin
                strobe_d = 1'b1;
                case (frame.addr)
                    ADDR_EN_OUT_LO: outLo_d = frame.data;
                    ADDR_EN_OUT_HI: outHi_d = frame.data;
                    ADDR_EN_PWM_LO: pwmLo_d = frame.data;
                    ADDR_EN_PWM_HI: pwmHi_d = frame.data;
                    ADDR_PWM_DUTY:  duty_d  = frame.data;
                    default: ;
                endcase
            end
        end else if (sclkRise && active_q && !ncsSync) begin
            shift_d = {shift_q[FRAME_W-2:0], copiSync};
            if (count_q != 5'd17) begin
                count_d = count_q + 5'd1;
            end
        end
    end

    // State and register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '0;
            count_q  <= '0;
            active_q <= 1'b0;
            strobe_q <= 1'b0;
            outLo_q  <= '0;
            outHi_q  <= '0;
            pwmLo_q  <= '0;
            pwmHi_q  <= '0;
            duty_q   <= '0;
        end else begin
            shift_q  <= shift_d;
            count_q  <= count_d;
            active_q <= active_d;
            strobe_q <= strobe_d;
            outLo_q  <= outLo_d;
            outHi_q  <= outHi_d;
            pwmLo_q  <= pwmLo_d;
            pwmHi_q  <= pwmHi_d;
            duty_q   <= duty_d;
        end
    end

    assign bus.en_reg_out_7_0  = outLo_q;
    assign bus.en_reg_out_15_8 = outHi_q;
    assign bus.en_reg_pwm_7_0  = pwmLo_q;
    assign bus.en_reg_pwm_15_8 = pwmHi_q;
    assign bus.pwm_duty_cycle  = duty_q;
    assign bus.wr_strobe       = strobe_q;

endmodule : spi_peripheral

// File: tb/tb_spi_peripheral.sv
// -----------------------------------------------------------------------------
// tb_spi_peripheral
// Drives SPI frames bit by bit on the pins and compares the register bank and
// the number of wr_strobe pulses against a simple array model of the register
// file, updated from the frame rules (length, write bit, address range).
// -----------------------------------------------------------------------------
module tb_spi_peripheral;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_peripheral_if bus();

    spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks      = 0;
    int errors      = 0;
    int strobeCount = 0;
    int expStrobes  = 0;
    int phase       = 5;
    logic [7:0] modelRegs [5];

    // Count strobe pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.wr_strobe === 1'b1) strobeCount++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] regValue(input int idx);
        case (idx)
            0:       return bus.en_reg_out_7_0;
            1:       return bus.en_reg_out_15_8;
            2:       return bus.en_reg_pwm_7_0;
            3:       return bus.en_reg_pwm_15_8;
            default: return bus.pwm_duty_cycle;
        endcase
    endfunction

    task automatic checkAll(input string tag);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("%s_reg%0d", tag, i), 32'(regValue(i)), 32'(modelRegs[i]));
        end
        checkOutput($sformatf("%s_strobes", tag), 32'(strobeCount), 32'(expStrobes));
    endtask

    task automatic shiftBits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.copi_in = bits[i];
            waitCycles(phase);
            bus.sclk_in = 1'b1;
            waitCycles(phase);
            bus.sclk_in = 1'b0;
        end
    endtask

    // Full frame of n bits; model follows the commit rule. Returns right
    // after ncs_in rises (at posedge + 1).
    task automatic applyStimulus(input logic [31:0] bits, input int n);
        bus.ncs_in = 1'b0;
        waitCycles(phase);
        shiftBits(bits, n);
        waitCycles(phase);
        bus.ncs_in = 1'b1;
        if (n == 16 && bits[15] == 1'b1 && bits[14:8] <= 7'h04) begin
            modelRegs[bits[10:8]] = bits[7:0];
            expStrobes++;
        end
    endtask

    initial begin
        logic [7:0] data;
        int         addr;

        bus.sclk_in = 1'b0;
        bus.copi_in = 1'b0;
        bus.ncs_in  = 1'b1;
        for (int i = 0; i < 5; i++) modelRegs[i] = 8'h00;

        waitCycles(3);
        rst = 1'b0;
        waitCycles(4);
        checkAll("reset");

        // First write with exact commit latency.
        applyStimulus(32'h8055, 16);
        waitCycles(3);
        checkOutput("lat_before_reg", 32'(bus.en_reg_out_7_0), 32'h00);
        checkOutput("lat_before_strobe", 32'(bus.wr_strobe), 32'h0);
        waitCycles(1);
        checkOutput("lat_at_reg", 32'(bus.en_reg_out_7_0), 32'h55);
        checkOutput("lat_at_strobe", 32'(bus.wr_strobe), 32'h1);
        waitCycles(1);
        checkOutput("lat_after_strobe", 32'(bus.wr_strobe), 32'h0);
        waitCycles(5);
        checkAll("write00");

        applyStimulus(32'h84F0, 16); waitCycles(6);
        checkOutput("duty_f0", 32'(bus.pwm_duty_cycle), 32'hF0);
        applyStimulus(32'h8480, 16); waitCycles(6);
        checkOutput("duty_80", 32'(bus.pwm_duty_cycle), 32'h80);
        applyStimulus(32'h04AA, 16); waitCycles(6);
        checkAll("readframe");

        applyStimulus(32'h85FF, 16); waitCycles(6);
        applyStimulus(32'hFF12, 16); waitCycles(6);
        checkAll("badaddr");

        applyStimulus(32'h81C3 >> 1, 15); waitCycles(6);
        applyStimulus({15'h0, 16'h81C3, 1'b1}, 17); waitCycles(6);
        checkAll("badlength");

        // Reset in the middle of a frame, then finish the frame's bits.
        bus.ncs_in = 1'b0;
        waitCycles(phase);
        shiftBits(32'h82, 8);
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) modelRegs[i] = 8'h00;
        shiftBits(32'h33, 8);
        waitCycles(phase);
        bus.ncs_in = 1'b1;
        waitCycles(6);
        checkAll("midreset");
        applyStimulus(32'h8233, 16); waitCycles(6);
        checkOutput("after_reset_pwm_lo", 32'(bus.en_reg_pwm_7_0), 32'h33);
        checkAll("after_reset");

        // Minimum legal sclk phase, random data across all addresses.
        phase = 4;
        for (int k = 0; k < 15; k++) begin
            addr = (k < 5) ? k : int'($urandom_range(0, 4));
            data = 8'($urandom);
            applyStimulus({16'h0, 1'b1, 7'(addr), data}, 16);
            waitCycles(6);
        end
        checkAll("random_min_phase");

        // Random mix of reads, writes and out-of-range addresses.
        for (int k = 0; k < 10; k++) begin
            applyStimulus({16'h0, 1'($urandom), 7'($urandom_range(0, 7)), 8'($urandom)}, 16);
            waitCycles(6);
        end
        checkAll("random_mix");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

endmodule : tb_spi_peripheral
